funct_generator_dac_reader: RTL and testbench

Consumer-side block for the generator FIFO. It pops fixed-point samples that the function generator wrote and truncates each one to the DAC word width. It then shifts the word out MSB-first on a 3-wire serial DAC interface (SCLK/SDATA/CS_N) at a programmable bit rate. It sits between the sample FIFO read port and the external DAC pins.

---
 rtl/funct_generator_pkg.sv | 14 +
 rtl/funct_generator_sclk_div.sv | 35 +++
 rtl/funct_generator_dac_reader.sv | 103 ++++++++++
 tb/tb_funct_generator_dac_reader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/funct_generator_pkg.sv
// Shared types and defaults for the function-generator FIFO consumer blocks.
package funct_generator_pkg;

   localparam int DEF_DAC_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      CAPT,
      SHIFT,
      GAP
   } dac_state_t;

endpackage

// File: rtl/funct_generator_sclk_div.sv
// SCLK divider: half-period counter, SCLK toggle and a strobe for the cycle
// that ends in a falling SCLK edge. tick also paces the inter-frame gap.
module funct_generator_sclk_div #(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 count_en,
   input  logic                 toggle_en,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 sclk,
   output logic                 tick,
   output logic                 fall
);

   logic [DIV_WIDTH-1:0] div_cnt;

   assign tick = count_en && (div_cnt == div);
   assign fall = tick && toggle_en && sclk;

   // NOTE: sequential state is updated with non-blocking assignments only,
   // so every flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst || !count_en) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
      end else if (tick) begin
         div_cnt <= '0;
         sclk    <= toggle_en ? ~sclk : 1'b0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/funct_generator_dac_reader.sv
// Pops samples from the generator FIFO and shifts the top DAC_WIDTH bits out
// MSB-first on SCLK/SDATA/CS_N. Define DAC_OFFSET_BIN_EN for offset-binary output.
module funct_generator_dac_reader
   import funct_generator_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int INT_BITS   = 4,
   parameter int DAC_WIDTH  = DEF_DAC_WIDTH,
   parameter int DIV_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_low_i,
   input  logic [DIV_WIDTH-1:0]  div_i,
   input  logic                  fifo_empty_i,
   input  logic [DATA_WIDTH-1:0] fifo_data_i,
   output logic                  fifo_rd_en_o,
   output logic                  sclk_o,
   output logic                  sdata_o,
   output logic                  cs_n_o,
   output logic                  busy_o,
   output logic                  underrun_o
);

   localparam int CNT_WIDTH = $clog2(DAC_WIDTH + 1);
   localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DAC_WIDTH - 1);

   dac_state_t           state, state_next;
   logic [DAC_WIDTH-1:0] shift_reg, capt_word;
   logic [DIV_WIDTH-1:0] div_q;
   logic [CNT_WIDTH-1:0] bit_cnt;
   logic                 cs_n_q, underrun_q;
   logic                 sclk, tick, fall;
   logic                 unused_bits;

   // Truncation keeps the integer bits, so INT_BITS and the low fraction bits are unused.
   assign unused_bits = ^{fifo_data_i, (INT_BITS != 0)};

`ifdef DAC_OFFSET_BIN_EN
   assign capt_word = fifo_data_i[DATA_WIDTH-1 -: DAC_WIDTH]
                    ^ (DAC_WIDTH'(1) << (DAC_WIDTH - 1));
`else
   assign capt_word = fifo_data_i[DATA_WIDTH-1 -: DAC_WIDTH];
`endif

   funct_generator_sclk_div #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_sclk_div (
      .clk       (clk),
      .rst       (rst),
      .count_en  ((state == SHIFT) || (state == GAP)),
      .toggle_en (state == SHIFT),
      .div       (div_q),
      .sclk      (sclk),
      .tick      (tick),
      .fall      (fall)
   );

   // NOTE: state_next gets its default before the case so no path infers a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!en_low_i && !fifo_empty_i) state_next = REQ;
         REQ:     state_next = CAPT;
         CAPT:    state_next = SHIFT;
         SHIFT:   if (fall && (bit_cnt == LAST_BIT)) state_next = GAP;
         GAP:     if (tick) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         shift_reg  <= '0;
         div_q      <= '0;
         bit_cnt    <= '0;
         cs_n_q     <= 1'b1;
         underrun_q <= 1'b0;
      end else begin
         state      <= state_next;
         cs_n_q     <= (state_next != SHIFT);
         underrun_q <= (state == IDLE) && !en_low_i && fifo_empty_i;
         if (state == CAPT) begin
            shift_reg <= capt_word;
            div_q     <= div_i;
            bit_cnt   <= '0;
         end else if (fall) begin
            // Zeros shift in, so SDATA rests low once the frame is done.
            shift_reg <= shift_reg << 1;
            bit_cnt   <= bit_cnt + 1'b1;
         end
      end
   end

   assign fifo_rd_en_o = (state == REQ);
   assign sclk_o       = sclk;
   assign sdata_o      = shift_reg[DAC_WIDTH-1];
   assign cs_n_o       = cs_n_q;
   assign busy_o       = (state != IDLE);
   assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_funct_generator_dac_reader.sv
// Scoreboard bench: a FIFO model feeds the DUT, a cycle-level waveform model
// predicts every output, and a serial decoder checks each shifted word.
module tb_funct_generator_dac_reader;

   localparam int DATA_WIDTH = 32;
   localparam int INT_BITS   = 4;
   localparam int DAC_WIDTH  = 16;
   localparam int DIV_WIDTH  = 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  en_low_i;
   logic [DIV_WIDTH-1:0]  div_i;
   logic                  fifo_empty_i;
   logic [DATA_WIDTH-1:0] fifo_data_i;
   logic                  fifo_rd_en_o, sclk_o, sdata_o, cs_n_o, busy_o, underrun_o;

   funct_generator_dac_reader #(
      .DATA_WIDTH (DATA_WIDTH),
      .INT_BITS   (INT_BITS),
      .DAC_WIDTH  (DAC_WIDTH),
      .DIV_WIDTH  (DIV_WIDTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en_low_i     (en_low_i),
      .div_i        (div_i),
      .fifo_empty_i (fifo_empty_i),
      .fifo_data_i  (fifo_data_i),
      .fifo_rd_en_o (fifo_rd_en_o),
      .sclk_o       (sclk_o),
      .sdata_o      (sdata_o),
      .cs_n_o       (cs_n_o),
      .busy_o       (busy_o),
      .underrun_o   (underrun_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [DATA_WIDTH-1:0] fq[$];
   logic [DAC_WIDTH-1:0]  exp_q[$];
   int                    pop_times[$];

   logic [DATA_WIDTH-1:0] data_next = '0;
   bit                    data_fresh = 1'b0;

   bit                   frame_active = 1'b0;
   int                   f_start, f_d, f_end, k, span;
   logic [DAC_WIDTH-1:0] f_word;
   bit                   prev_ready = 1'b0, prev_under = 1'b0, idle_now, exp_rd;
   logic                 e_cs, e_sclk;
   logic [DATA_WIDTH-1:0] w;

   logic                 prev_sclk = 1'b0, prev_cs_n = 1'b1;
   logic [DAC_WIDTH-1:0] dec_word = '0;
   int                   dec_nbits = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
   endtask

   // The DAC word is the top DAC_WIDTH bits; offset binary flips the sign bit.
   function automatic logic [DAC_WIDTH-1:0] dac_word(input logic [DATA_WIDTH-1:0] x);
      logic [DAC_WIDTH-1:0] r;
      r = x[DATA_WIDTH-1 -: DAC_WIDTH];
`ifdef DAC_OFFSET_BIN_EN
      r[DAC_WIDTH-1] = ~r[DAC_WIDTH-1];
`endif
      return r;
   endfunction

   // FIFO read port: data appears the cycle after a pop, garbage otherwise.
   always @(posedge clk) begin
      #1;
      fifo_data_i  = data_fresh ? data_next : $urandom();
      data_fresh   = 1'b0;
      fifo_empty_i = (fq.size() == 0);
   end

   // Monitor: reference waveform, pop bookkeeping and serial decoder.
   always @(negedge clk) begin
      cyc++;
      w = '0;
      if (fifo_rd_en_o === 1'b1) begin
         if (fq.size() > 0) w = fq.pop_front();
         data_next  = w;
         data_fresh = 1'b1;
      end
      if (rst) begin
         frame_active = 1'b0;
         prev_ready   = 1'b0;
         prev_under   = 1'b0;
         exp_q.delete();
         dec_word     = '0;
         dec_nbits    = 0;
         prev_sclk    = 1'b0;
         prev_cs_n    = 1'b1;
      end else begin
         exp_rd = prev_ready;
         check("fifo_rd_en", 32'(fifo_rd_en_o), 32'(exp_rd));
         if (fifo_rd_en_o === 1'b1) begin
            check("rd_while_empty", 32'(fifo_empty_i), 32'(0));
            exp_q.push_back(dac_word(w));
            pop_times.push_back(cyc);
         end
         if (exp_rd) begin
            frame_active = 1'b1;
            f_start      = cyc;
            f_word       = dac_word(w);
            f_end        = 1 << 30;
         end
         check("underrun", 32'(underrun_o), 32'(prev_under));

         idle_now = 1'b1;
         e_cs     = 1'b1;
         e_sclk   = 1'b0;
         if (frame_active) begin
            k = cyc - f_start;
            if (k == 1) begin
               f_d   = int'(div_i);
               f_end = 2 + 2 * DAC_WIDTH * (f_d + 1) + (f_d + 1);
            end
            if (k < f_end) begin
               idle_now = 1'b0;
               span     = 2 * DAC_WIDTH * (f_d + 1);
               if (k >= 2 && k < 2 + span) begin
                  e_cs   = 1'b0;
                  e_sclk = (((k - 2) / (f_d + 1)) % 2) == 1;
                  check("sdata", 32'(sdata_o),
                        32'(f_word[DAC_WIDTH - 1 - ((k - 2) / (2 * (f_d + 1)))]));
               end
            end else begin
               frame_active = 1'b0;
            end
         end
         check("busy", 32'(busy_o), 32'(!idle_now));
         check("cs_n", 32'(cs_n_o), 32'(e_cs));
         check("sclk", 32'(sclk_o), 32'(e_sclk));

         if (!cs_n_o && sclk_o && !prev_sclk) begin
            dec_word = {dec_word[DAC_WIDTH-2:0], sdata_o};
            dec_nbits++;
         end
         if (cs_n_o && !prev_cs_n) begin
            check("frame_bits", 32'(dec_nbits), 32'(DAC_WIDTH));
            if (exp_q.size() == 0) check("frame_unexpected", 32'(exp_q.size()), 32'(1));
            else check("frame_word", 32'(dec_word), 32'(exp_q.pop_front()));
            dec_word  = '0;
            dec_nbits = 0;
         end
         prev_sclk  = sclk_o;
         prev_cs_n  = cs_n_o;
         prev_ready = idle_now && !en_low_i && !fifo_empty_i;
         prev_under = idle_now && !en_low_i && fifo_empty_i;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain(input int budget);
      int quiet = 0;
      for (int i = 0; i < budget && quiet < 3; i++) begin
         tick(1);
         if (fq.size() == 0 && !busy_o) quiet++;
         else quiet = 0;
      end
      check("drain_timeout", 32'(quiet), 32'(3));
   endtask

   task automatic wait_bits(input int n, input int budget);
      for (int i = 0; i < budget && dec_nbits < n; i++) tick(1);
      check("wait_bits_timeout", 32'(dec_nbits >= n), 32'(1));
   endtask

   initial begin
      rst          = 1'b1;
      en_low_i     = 1'b1;
      div_i        = '0;
      fifo_empty_i = 1'b1;
      fifo_data_i  = '0;
      tick(2);
      @(negedge clk);
      check("rst_rd_en", 32'(fifo_rd_en_o), 32'(0));
      check("rst_sclk", 32'(sclk_o), 32'(0));
      check("rst_sdata", 32'(sdata_o), 32'(0));
      check("rst_cs_n", 32'(cs_n_o), 32'(1));
      check("rst_busy", 32'(busy_o), 32'(0));
      check("rst_underrun", 32'(underrun_o), 32'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick(2);

      // D=0 back-to-back pair: 36-cycle frame period.
      pop_times.delete();
      div_i = 8'd0;
      fq.push_back(32'h1234_5678);
      fq.push_back(32'h8000_0000);
      tick(2);
      en_low_i = 1'b0;
      wait_drain(400);
      check("pop_count", 32'(pop_times.size()), 32'(2));
      if (pop_times.size() >= 2)
         check("pop_period", 32'(pop_times[1] - pop_times[0]), 32'(36));

      // D=3 with a mid-frame div_i change that must be ignored.
      div_i = 8'd3;
      fq.push_back(32'hFFFF_0000);
      tick(20);
      div_i = 8'd1;
      wait_drain(600);

      // Underrun while enabled and empty, then data arrives.
      tick(5);
      @(negedge clk);
      check("underrun_high", 32'(underrun_o), 32'(1));
      check("no_pop_when_empty", 32'(fifo_rd_en_o), 32'(0));
      @(posedge clk);
      #1;
      fq.push_back(32'hA5C3_0F0F);
      wait_drain(400);

      // Reset after the fifth SCLK rise: that sample is dropped, not re-sent.
      en_low_i = 1'b1;
      div_i    = 8'd1;
      fq.push_back(32'h0BAD_1111);
      fq.push_back(32'h600D_2222);
      tick(2);
      en_low_i = 1'b0;
      wait_bits(5, 200);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      wait_drain(600);

      // Disable at bit 8: the frame completes and nothing more is popped.
      en_low_i = 1'b1;
      div_i    = 8'd0;
      fq.push_back(32'h1111_0000);
      fq.push_back(32'h2222_0000);
      fq.push_back(32'h3333_0000);
      tick(2);
      en_low_i = 1'b0;
      wait_bits(8, 200);
      en_low_i = 1'b1;
      for (int i = 0; i < 200 && busy_o; i++) tick(1);
      tick(5);
      check("no_pop_after_disable", 32'(fq.size()), 32'(2));
      check("idle_after_disable", 32'(busy_o), 32'(0));
      en_low_i = 1'b0;
      wait_drain(400);

      // Randomised traffic: pushes, enable toggles, divider changes, resets.
      for (int i = 0; i < 3000; i++) begin
         tick(1);
         if ($urandom_range(3) == 0 && fq.size() < 3) fq.push_back($urandom());
         if ($urandom_range(39) == 0) en_low_i = ~en_low_i;
         if ($urandom_range(24) == 0) div_i = DIV_WIDTH'($urandom_range(3));
         if ($urandom_range(1199) == 0) begin
            rst = 1'b1;
            tick(1);
            rst = 1'b0;
         end
      end
      en_low_i = 1'b0;
      wait_drain(3000);
      check("scoreboard_leftover", 32'(exp_q.size()), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
